systolic_skew_buffer: RTL and testbench

Multi-lane, parametrised skew/de-skew buffer for the systolic data-setup path. It feeds one row or column of the PE array: lane k of a parallel input vector is delayed by a lane-dependent number of cycles, so operands enter the array diagonally (skew). The same block, in de-skew mode, re-aligns the diagonal result wavefront at the array output. Each lane carries a valid bit, and invalid beats are zero-padded. A drain FSM flushes the pipeline at the end of a tile and signals completion.

---
 rtl/systolic_setup_pkg.sv | 21 ++
 rtl/skew_lane.sv | 41 ++++
 rtl/systolic_skew_buffer.sv | 106 ++++++++++
 tb/tb_systolic_skew_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_setup_pkg.sv
// Shared types and lane-depth rule for the systolic data-setup path.
// Used by the skew buffer top and its per-lane delay lines.
package systolic_setup_pkg;

    typedef enum logic {
        SKEW_MODE   = 1'b0,
        DESKEW_MODE = 1'b1
    } skew_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } drain_state_e;

    // Skew pushes operands onto a diagonal; de-skew undoes exactly that diagonal.
    function automatic int lane_depth(input int k, input int n, input skew_mode_e mode);
        return (mode == SKEW_MODE) ? (k + 1) : (n - k);
    endfunction

endpackage

// File: rtl/skew_lane.sv
// Purpose: single-lane (data, valid) delay line of DEPTH registers.
// Latency: DEPTH advancing (EN=1) cycles from ins_* to out_*.
// Backpressure: none inside the lane; EN=0 freezes every stage.
module skew_lane #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         ASYNC_RST,
    input  logic                         SYNC_RST,
    input  logic                         EN,
    input  logic                         ins_vld,
    input  logic signed [DATA_WIDTH-1:0] ins_dat,
    output logic                         out_vld,
    output logic signed [DATA_WIDTH-1:0] out_dat
);

    logic signed [DATA_WIDTH-1:0] dat_q [DEPTH];
    logic        [DEPTH-1:0]      vld_q;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else if (SYNC_RST) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else if (EN) begin
            vld_q[0] <= ins_vld;
            dat_q[0] <= ins_dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_buffer.sv
// Purpose: per-lane skew/de-skew of a vector feeding the PE array, with tile drain FSM.
// Latency: lane k = lane_depth(k) advancing cycles; outputs registered, no input-to-output path.
// Backpressure: In_Ready drops only while draining; EN=0 stalls every register in place.
module systolic_skew_buffer
    import systolic_setup_pkg::*;
#(
    parameter int         N_LANES    = 4,
    parameter int         DATA_WIDTH = 32,
    parameter skew_mode_e MODE       = SKEW_MODE
) (
    input  logic                          CLK,
    input  logic                          ASYNC_RST,
    input  logic                          SYNC_RST,
    input  logic                          EN,
    input  logic                          In_Valid,
    output logic                          In_Ready,
    input  logic [N_LANES*DATA_WIDTH-1:0] In_Data,
    input  logic                          Drain,
    output logic [N_LANES*DATA_WIDTH-1:0] Out_Data,
    output logic [N_LANES-1:0]            Out_Valid,
    output logic                          Busy,
    output logic                          Drain_Done
);

    localparam int            CW       = $clog2(N_LANES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N_LANES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);

    drain_state_e  state;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic          accept;

    assign In_Ready   = (state != DRAIN);
    assign Busy       = (state != IDLE);
    assign Drain_Done = done_q;
    assign accept     = EN & In_Valid & In_Ready;

    // Rejected beats insert zero, so every invalid register already holds 0.
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        localparam int D = lane_depth(k, N_LANES, MODE);
        logic signed [DATA_WIDTH-1:0] ins_dat;

        assign ins_dat = accept ? In_Data[k*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_lane #(
            .DEPTH      (D),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .CLK       (CLK),
            .ASYNC_RST (ASYNC_RST),
            .SYNC_RST  (SYNC_RST),
            .EN        (EN),
            .ins_vld   (accept),
            .ins_dat   (ins_dat),
            .out_vld   (Out_Valid[k]),
            .out_dat   (Out_Data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Drain_Done is set one advance early so it coincides with the last DRAIN cycle,
    // when the deepest lane presents the final accepted beat.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (SYNC_RST) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (EN) begin
                case (state)
                    IDLE: begin
                        if (Drain)  done_q <= 1'b1;
                        if (accept) state  <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (Drain) begin
                            state  <= DRAIN;
                            cnt    <= CNT_LOAD;
                            done_q <= (N_LANES == 1);
                        end
                    end
                    DRAIN: begin
                        if (cnt == CNT_ONE) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt    <= cnt - CNT_ONE;
                            done_q <= (cnt == CNT_TWO);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Scoreboard bench: skew and de-skew instances share stimulus; a timeline model
// predicts when each accepted lane value must appear and when Drain_Done must fire.
module tb_systolic_skew_buffer;
    import systolic_setup_pkg::*;

    localparam int NL = 4;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          ASYNC_RST = 1'b0;
    logic          SYNC_RST = 1'b0;
    logic          EN = 1'b0;
    logic          In_Valid = 1'b0;
    logic          Drain = 1'b0;
    logic [31:0]   In_Data = '0;

    logic          rdy_s, rdy_d, busy_s, busy_d, done_s, done_d;
    logic [31:0]   od_s, od_d;
    logic [3:0]    ov_s, ov_d;

    always #5 CLK = ~CLK;

    systolic_skew_buffer #(.N_LANES(NL), .DATA_WIDTH(DW), .MODE(SKEW_MODE)) u_skew (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .In_Valid(In_Valid), .In_Ready(rdy_s), .In_Data(In_Data), .Drain(Drain),
        .Out_Data(od_s), .Out_Valid(ov_s), .Busy(busy_s), .Drain_Done(done_s));

    systolic_skew_buffer #(.N_LANES(NL), .DATA_WIDTH(DW), .MODE(DESKEW_MODE)) u_deskew (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .In_Valid(In_Valid), .In_Ready(rdy_d), .In_Data(In_Data), .Drain(Drain),
        .Out_Data(od_d), .Out_Valid(ov_d), .Busy(busy_d), .Drain_Done(done_d));

    typedef struct {
        int         inst;
        int         lane;
        int         due;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];
    int   done_q[$];
    int   adv = 0;
    int   cur_idx = -1;
    bit   last_adv = 0;
    bit   busy_m = 0;
    int   drain_cnt = 0;
    int   flush_cnt = 0;

    int   checks = 0;
    int   errors = 0;

    function automatic int ref_depth(input int m, input int k);
        return (m == 0) ? (k + 1) : (NL - k);
    endfunction

    function automatic void clear_model();
        sb.delete();
        done_q.delete();
        busy_m    = 0;
        drain_cnt = 0;
        last_adv  = 0;
        flush_cnt = flush_cnt + 1;
    endfunction

    // Reference timeline: each accepted value is due on lane k after depth-1 further advances.
    always @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            clear_model();
        end else if (SYNC_RST) begin
            clear_model();
        end else if (EN) begin
            bit pre_busy;
            int pre_cnt;
            bit acc;
            pre_busy = busy_m;
            pre_cnt  = drain_cnt;
            acc      = In_Valid && (pre_cnt == 0);
            if (acc) begin
                for (int m = 0; m < 2; m++)
                    for (int k = 0; k < NL; k++) begin
                        exp_t e;
                        e.inst = m;
                        e.lane = k;
                        e.due  = adv + ref_depth(m, k) - 1;
                        e.dat  = In_Data[k*8 +: 8];
                        sb.push_back(e);
                    end
            end
            if (pre_cnt > 0) begin
                drain_cnt = pre_cnt - 1;
                if (drain_cnt == 0) busy_m = 0;
            end else if (Drain) begin
                if (!pre_busy) begin
                    done_q.push_back(adv);
                end else begin
                    drain_cnt = NL;
                    done_q.push_back(adv + NL - 1);
                end
            end
            if (acc) busy_m = 1;
            last_adv = 1;
            cur_idx  = adv;
            adv      = adv + 1;
        end else begin
            last_adv = 0;
        end
    end

    task automatic chk(input string name, input int m, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s inst%0d lane%0d t=%0t actual=%h expected=%h", name, m, k, $time, act, exp);
        end
    endtask

    logic       hold_v [2][NL];
    logic [7:0] hold_d [2][NL];
    int         flush_seen = 0;

    always @(negedge CLK) begin
        bit exp_done;
        exp_done = 0;
        if (flush_seen != flush_cnt) begin
            flush_seen = flush_cnt;
            for (int m = 0; m < 2; m++)
                for (int k = 0; k < NL; k++) begin
                    hold_v[m][k] = 1'b0;
                    hold_d[m][k] = 8'h00;
                end
        end
        if (last_adv) begin
            for (int m = 0; m < 2; m++)
                for (int k = 0; k < NL; k++) begin
                    hold_v[m][k] = 1'b0;
                    hold_d[m][k] = 8'h00;
                end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cur_idx) begin
                    hold_v[sb[i].inst][sb[i].lane] = 1'b1;
                    hold_d[sb[i].inst][sb[i].lane] = sb[i].dat;
                    sb.delete(i);
                end
            end
            if (done_q.size() > 0 && done_q[0] == cur_idx) begin
                exp_done = 1;
                void'(done_q.pop_front());
            end
        end
        chk("in_ready",   0, 0, {31'd0, rdy_s},  {31'd0, drain_cnt == 0});
        chk("in_ready",   1, 0, {31'd0, rdy_d},  {31'd0, drain_cnt == 0});
        chk("busy",       0, 0, {31'd0, busy_s}, {31'd0, busy_m});
        chk("busy",       1, 0, {31'd0, busy_d}, {31'd0, busy_m});
        chk("drain_done", 0, 0, {31'd0, done_s}, {31'd0, exp_done});
        chk("drain_done", 1, 0, {31'd0, done_d}, {31'd0, exp_done});
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NL; k++) begin
                logic [3:0]  ov;
                logic [31:0] od;
                ov = (m == 0) ? ov_s : ov_d;
                od = (m == 0) ? od_s : od_d;
                chk("lane_out", m, k, {23'd0, ov[k], od[k*8 +: 8]},
                    {23'd0, hold_v[m][k], hold_v[m][k] ? hold_d[m][k] : 8'h00});
            end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic en,
                         input logic dr, input logic sr);
        @(posedge CLK);
        #1;
        In_Valid = v;
        In_Data  = d;
        EN       = en;
        Drain    = dr;
        SYNC_RST = sr;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 ASYNC_RST = 1'b1;
        EN = 1'b1;
        drive(0, 32'h0, 1, 0, 0);

        // Single skewed beat, then idle so each lane's lone valid can be seen.
        drive(1, 32'h04030201, 1, 0, 0);
        repeat (6) drive(0, 32'h0, 1, 0, 0);

        // Diagonal wavefront: the de-skew instance must realign it.
        drive(1, 32'h00000001, 1, 0, 0);
        drive(1, 32'h00000200, 1, 0, 0);
        drive(1, 32'h00030000, 1, 0, 0);
        drive(1, 32'h04000000, 1, 0, 0);
        repeat (6) drive(0, 32'h0, 1, 0, 0);

        // Stream with a 3-cycle stall in the middle.
        for (int i = 0; i < 4; i++) drive(1, $urandom, 1, 0, 0);
        repeat (3) drive(1, $urandom, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, $urandom, 1, 0, 0);

        // Five beats, Drain with the fifth, then watch the flush.
        for (int i = 0; i < 4; i++) drive(1, $urandom, 1, 0, 0);
        drive(1, $urandom, 1, 1, 0);
        repeat (6) drive(1, $urandom, 1, 0, 0);

        // Back in ACTIVE from the stream above; drain to IDLE, then Drain in IDLE.
        drive(0, 32'h0, 1, 1, 0);
        repeat (5) drive(0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 1, 1, 0);
        repeat (3) drive(0, 32'h0, 1, 0, 0);

        // SYNC_RST while draining aborts with no completion pulse.
        for (int i = 0; i < 3; i++) drive(1, $urandom, 1, 0, 0);
        drive(1, $urandom, 1, 1, 0);
        drive(0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 1, 0, 1);
        repeat (4) drive(0, 32'h0, 1, 0, 0);

        // Asynchronous reset mid-stream, checked before any further rising edge.
        for (int i = 0; i < 3; i++) drive(1, $urandom, 1, 0, 0);
        @(posedge CLK);
        #2 ASYNC_RST = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1 ASYNC_RST = 1'b1;

        // Randomized mix of beats, stalls, drains and occasional synchronous clears.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 199) == 0);
        end
        repeat (8) drive(0, 32'h0, 1, 0, 0);

        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
